// File: rtl/dmem_store_buffer.sv
// ============================================================================
// Module   : dmem_store_buffer
// Brief    : Posted-write FIFO between the core data port and the data RAM.
//            Loads take priority and wait on word-address hits in the buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cpu_req,
    input  logic                       cpu_we,
    input  logic [3:0]                 cpu_be,
    input  logic [AW-1:0]              cpu_addr,
    input  logic [DW-1:0]              cpu_wdata,
    output logic                       cpu_stall,
    output logic                       cpu_rvalid,
    output logic [DW-1:0]              cpu_rdata,
    input  logic                       ram_busy,
    output logic                       ram_ena,
    output logic [3:0]                 ram_wea,
    output logic [AW-1:0]              ram_addr,
    output logic [DW-1:0]              ram_dina,
    input  logic [DW-1:0]              ram_douta,
    output logic [$clog2(DEPTH):0]     buf_count,
    output logic                       buf_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [AW-3:0]   addr_q  [DEPTH];
    logic [DW-1:0]   data_q  [DEPTH];
    logic [3:0]      be_q    [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic full;
    logic hazard;
    logic push;
    logic load_issue;
    logic drain;

    assign full = (count == FULL_COUNT);

    // Hazard looks only at pre-edge contents, so a same-cycle push never matches.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == cpu_addr[AW-1:2]))
                hazard = 1'b1;
        end
    end

    assign push       = cpu_req && cpu_we && !full;
    assign load_issue = cpu_req && !cpu_we && !hazard && !ram_busy;
    assign drain      = !ram_busy && !load_issue && (count != '0);

    always_comb begin
        cpu_stall = 1'b0;
        if (cpu_req)
            cpu_stall = cpu_we ? full : (hazard || ram_busy);
    end

    always_comb begin
        ram_ena  = 1'b0;
        ram_wea  = 4'h0;
        ram_addr = '0;
        ram_dina = '0;
        if (load_issue) begin
            ram_ena  = 1'b1;
            ram_addr = {cpu_addr[AW-1:2], 2'b00};
        end else if (drain) begin
            ram_ena  = 1'b1;
            ram_wea  = be_q[rd_ptr];
            ram_addr = {addr_q[rd_ptr], 2'b00};
            ram_dina = data_q[rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            valid_q    <= '0;
            cpu_rvalid <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= 4'h0;
            end
        end else begin
            cpu_rvalid <= load_issue;
            if (push) begin
                addr_q[wr_ptr]  <= cpu_addr[AW-1:2];
                data_q[wr_ptr]  <= cpu_wdata;
                be_q[wr_ptr]    <= cpu_be;
                valid_q[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            // Push can only land on a free slot, so it never collides with the popped head.
            if (drain) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
            end
            if (push && !drain)
                count <= count + 1'b1;
            else if (drain && !push)
                count <= count - 1'b1;
        end
    end

    assign cpu_rdata = ram_douta;
    assign buf_count = count;
    assign buf_empty = (count == '0);

endmodule

`default_nettype wire

// File: tb/tb_dmem_store_buffer.sv
// ============================================================================
// Module   : tb_dmem_store_buffer
// Brief    : Directed self-checking bench for dmem_store_buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        ram_busy;
    logic        ram_ena;
    logic [3:0]  ram_wea;
    logic [31:0] ram_addr;
    logic [31:0] ram_dina;
    logic [31:0] ram_douta;
    logic [2:0]  buf_count;
    logic        buf_empty;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [64];

    always #5 clk = ~clk;

    dmem_store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ram_busy(ram_busy), .ram_ena(ram_ena), .ram_wea(ram_wea),
        .ram_addr(ram_addr), .ram_dina(ram_dina), .ram_douta(ram_douta),
        .buf_count(buf_count), .buf_empty(buf_empty)
    );

    // Byte-lane synchronous RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (ram_ena) begin
            if (ram_wea == 4'h0) begin
                ram_douta <= mem[ram_addr[7:2]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (ram_wea[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_dina[8*b +: 8];
            end
        end
    end

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            checks++;
            if (buf_empty !== (buf_count == 3'd0)) begin
                errors++;
                $error("FAIL mon_empty observed %0h expected %0h", buf_empty, (buf_count == 3'd0));
            end
            if (ram_ena === 1'b1) begin
                checks++;
                if (ram_addr[1:0] !== 2'b00) begin
                    errors++;
                    $error("FAIL mon_addr_lsb observed %0h expected %0h", ram_addr[1:0], 2'b00);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 4'h0;
        cpu_addr = '0; cpu_wdata = '0; ram_busy = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                         input logic busy);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d; cpu_be = be;
        ram_busy = busy;
    endtask

    task automatic load(input logic [31:0] a, input logic busy);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a; cpu_wdata = '0; cpu_be = 4'h0;
        ram_busy = busy;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[32] = 32'hCAFEF00D;
        ram_douta = 32'h0;
        idle();
        rst = 1'b1;
        #1;
        chk("reset_count", buf_count, 3'd0);
        chk("reset_empty", buf_empty, 1'b1);
        chk("reset_rvalid", cpu_rvalid, 1'b0);
        chk("reset_ena", ram_ena, 1'b0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Single store drains exactly one cycle later
        store(32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        #1;
        chk("st_stall", cpu_stall, 1'b0);
        chk("st_no_bypass", ram_ena, 1'b0);
        tick();
        idle(); #1;
        chk("st_ena", ram_ena, 1'b1);
        chk("st_wea", ram_wea, 4'hF);
        chk("st_addr", ram_addr, 32'h10);
        chk("st_dina", ram_dina, 32'hDEADBEEF);
        tick(); #1;
        chk("st_empty", buf_empty, 1'b1);
        chk("st_idle_ena", ram_ena, 1'b0);
        chk("st_mem", mem[4], 32'hDEADBEEF);

        // Load priority over pending drains
        store(32'h40, 32'h4040, 4'hF, 1'b1); tick();
        store(32'h44, 32'h4444, 4'hF, 1'b1); tick();
        load(32'h80, 1'b0); #1;
        chk("lp_count", buf_count, 3'd2);
        chk("lp_ena", ram_ena, 1'b1);
        chk("lp_wea", ram_wea, 4'h0);
        chk("lp_addr", ram_addr, 32'h80);
        chk("lp_stall", cpu_stall, 1'b0);
        tick();
        idle(); #1;
        chk("lp_rvalid", cpu_rvalid, 1'b1);
        chk("lp_rdata", cpu_rdata, 32'hCAFEF00D);
        chk("lp_drain0_addr", ram_addr, 32'h40);
        chk("lp_drain0_wea", ram_wea, 4'hF);
        tick(); #1;
        chk("lp_rvalid_off", cpu_rvalid, 1'b0);
        chk("lp_drain1_addr", ram_addr, 32'h44);
        chk("lp_drain1_dina", ram_dina, 32'h4444);
        tick(); #1;
        chk("lp_empty", buf_empty, 1'b1);

        // Read-after-write hazard
        store(32'h20, 32'h12345678, 4'hF, 1'b0); tick();
        load(32'h22, 1'b1); #1;
        chk("raw_c1_stall", cpu_stall, 1'b1);
        chk("raw_c1_ena", ram_ena, 1'b0);
        tick();
        load(32'h22, 1'b0); #1;
        chk("raw_c2_stall", cpu_stall, 1'b1);
        chk("raw_c2_ena", ram_ena, 1'b1);
        chk("raw_c2_wea", ram_wea, 4'hF);
        chk("raw_c2_addr", ram_addr, 32'h20);
        chk("raw_c2_dina", ram_dina, 32'h12345678);
        tick(); #1;
        chk("raw_c3_stall", cpu_stall, 1'b0);
        chk("raw_c3_wea", ram_wea, 4'h0);
        chk("raw_c3_addr", ram_addr, 32'h20);
        tick();
        idle(); #1;
        chk("raw_c4_rvalid", cpu_rvalid, 1'b1);
        chk("raw_c4_rdata", cpu_rdata, 32'h12345678);
        tick();

        // Fill to full, then drain in order with pointer wrap
        for (int i = 0; i < 4; i++) begin
            store(32'(4 * i), 32'h100 + 32'(i), 4'hF, 1'b1);
            tick();
        end
        store(32'h50, 32'h55, 4'hF, 1'b1); #1;
        chk("full_count", buf_count, 3'd4);
        chk("full_stall", cpu_stall, 1'b1);
        tick();
        ram_busy = 1'b0; #1;
        chk("full_d0_stall", cpu_stall, 1'b1);
        chk("full_d0_addr", ram_addr, 32'h0);
        chk("full_d0_dina", ram_dina, 32'h100);
        tick(); #1;
        chk("full_d1_stall", cpu_stall, 1'b0);
        chk("full_d1_addr", ram_addr, 32'h4);
        tick();
        idle(); #1;
        chk("full_d2_count", buf_count, 3'd3);
        chk("full_d2_addr", ram_addr, 32'h8);
        tick(); #1;
        chk("full_d3_addr", ram_addr, 32'hC);
        chk("full_d3_dina", ram_dina, 32'h103);
        tick(); #1;
        chk("full_d4_addr", ram_addr, 32'h50);
        chk("full_d4_dina", ram_dina, 32'h55);
        tick(); #1;
        chk("full_empty", buf_empty, 1'b1);

        // Partial byte lane write
        store(32'h30, 32'hAABBCCDD, 4'b0010, 1'b0); tick();
        idle(); #1;
        chk("bl_wea", ram_wea, 4'b0010);
        chk("bl_addr", ram_addr, 32'h30);
        tick();
        load(32'h30, 1'b0); tick();
        idle(); #1;
        chk("bl_rdata", cpu_rdata, 32'h0000CC00);
        tick();

        // Asynchronous reset with three buffered stores
        store(32'h60, 32'h6060, 4'hF, 1'b1); tick();
        store(32'h64, 32'h6464, 4'hF, 1'b1); tick();
        load(32'h80, 1'b0); tick();
        store(32'h68, 32'h6868, 4'hF, 1'b1); #1;
        chk("rst_pre_count", buf_count, 3'd2);
        chk("rst_pre_rvalid", cpu_rvalid, 1'b1);
        tick();
        idle(); ram_busy = 1'b1; #1;
        chk("rst_pre_count3", buf_count, 3'd3);
        rst = 1'b1; #1;
        chk("rst_count", buf_count, 3'd0);
        chk("rst_empty", buf_empty, 1'b1);
        chk("rst_rvalid", cpu_rvalid, 1'b0);
        tick();
        rst = 1'b0; ram_busy = 1'b0; #1;
        chk("rst_idle_ena0", ram_ena, 1'b0);
        tick(); #1;
        chk("rst_idle_ena1", ram_ena, 1'b0);
        tick(); #1;
        chk("rst_no_stale0", mem[24], 32'h0);
        chk("rst_no_stale2", mem[26], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/dmem_store_buffer.md
# dmem_store_buffer

Posted-write buffer between the MIPS core's data port and the synchronous data RAM. It accepts stores from the core into a small in-order FIFO and retires them to the RAM when the RAM port is idle. Loads are given priority on the RAM port. A load whose word address matches a buffered store is held until that store has drained, so read-after-write ordering is preserved.

## Interface

Parameters:
- `DEPTH`, default 4: buffer entries; must be a power of 2, minimum 2.
- `AW`, default 32: address width in bits.
- `DW`, default 32: data width in bits; fixed at 4 byte lanes.

Ports:
- `clk` input, 1: the only clock. All state changes on the rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `cpu_req` input, 1: core requests a data access this cycle.
- `cpu_we` input, 1: 1 = store, 0 = load. Qualified by `cpu_req`.
- `cpu_be` input, 4: byte enables for a store. Ignored for a load.
- `cpu_addr` input, AW: byte address. Bits [1:0] are ignored (word granularity).
- `cpu_wdata` input, DW: store data.
- `cpu_stall` output, 1: combinational. 1 = this request is not accepted this cycle; the core must hold the request.
- `cpu_rvalid` output, 1: registered. The load issued in the previous cycle has returned data.
- `cpu_rdata` output, DW: equals `ram_douta`. Valid only when `cpu_rvalid` = 1.
- `ram_busy` input, 1: 1 = no RAM access may be issued this cycle.
- `ram_ena` output, 1: RAM access strobe.
- `ram_wea` output, 4: RAM byte write enables. 0 for a read.
- `ram_addr` output, AW: RAM byte address, with bits [1:0] forced to 0.
- `ram_dina` output, DW: RAM write data.
- `ram_douta` input, DW: RAM read data. Valid one cycle after a read is issued.
- `buf_count` output, log2(DEPTH)+1: number of occupied entries.
- `buf_empty` output, 1: `buf_count` == 0.

## Operation

- Storage: a circular FIFO with write pointer, read pointer and count. Each entry holds a word address, DW data and 4 byte enables.
- Store accept: accepted when `cpu_req`=1, `cpu_we`=1 and `buf_count` < `DEPTH`. The entry is written at the clock edge. When the buffer is full, `cpu_stall`=1, even if a drain happens in the same cycle; push-on-full is not allowed.
- Load hazard: the hazard flag is 1 when any valid entry's `addr[AW-1:2]` equals `cpu_addr[AW-1:2]`. The comparison is against the state before the edge, so a same-cycle push cannot create a hazard.
- Load issue: issued when `cpu_req`=1, `cpu_we`=0, no hazard and `ram_busy`=0. The block drives `ram_ena`=1, `ram_wea`=0 and `ram_addr`=`cpu_addr`; `cpu_stall`=0. If there is a hazard or `ram_busy`=1, `cpu_stall`=1 and nothing is issued for the load.
- Drain: in any cycle with `ram_busy`=0, no load being issued and `buf_count` > 0, the head entry is driven onto the RAM port. The block drives `ram_ena`=1, `ram_wea` = entry byte enables, `ram_addr` = entry address and `ram_dina` = entry data. The head is popped at the edge.
- Drain during a hazard stall: a hazard-stalled load does not occupy the port, so a drain proceeds in that cycle.
- Store bypass: a store is never written straight through to the RAM. An accepted store is drained no earlier than the next cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointer wrap: pointers wrap modulo `DEPTH`.
- Drain order: stores drain strictly in acceptance order.
- Idle RAM outputs: when neither a load nor a drain is issued, `ram_ena`=0, `ram_wea`=0, `ram_addr`=0 and `ram_dina`=0.

## Timing

- Reset values (asynchronous): pointers 0, `buf_count`=0, `buf_empty`=1, `cpu_rvalid`=0.
  - Outputs that are combinational become `ram_ena`=0 and `ram_wea`=0 unless a load is requested.
  - Buffered stores are discarded on reset. Asserting `rst` mid-drain aborts the remaining entries; the RAM write in that cycle is not guaranteed.
- Load latency: a load issued in cycle N gives `cpu_rvalid`=1 in cycle N+1, with `cpu_rdata` = `ram_douta`.
- Store latency: a store accepted in cycle N is written to RAM no earlier than cycle N+1. With the port free and the buffer otherwise empty, it is written exactly in N+1.
- Drain rate: at most one drain per cycle.
- `cpu_stall` depends combinationally on `cpu_req`, `cpu_we`, `cpu_addr`, `ram_busy` and registered state only.

## Test plan

- Reset: assert `rst` mid-run with 3 entries buffered.
  - Required: `buf_count`=0, `buf_empty`=1, `cpu_rvalid`=0 immediately.
  - Required: `ram_ena`=0 while idle, and no stale writes after release.
- Single store: store to 0x10, data 0xDEADBEEF, be=4'hF, in cycle 0, then idle.
  - Required: cycle 1 `ram_ena`=1, `ram_wea`=4'hF, `ram_addr`=0x10, `ram_dina`=0xDEADBEEF.
  - Required: `buf_empty`=1 from cycle 2.
- Load priority: buffer holds 2 stores to 0x40 and 0x44; load 0x80 in cycle 0.
  - Required: cycle 0 read of 0x80 with no drain.
  - Required: cycle 1 `cpu_rvalid`=1, and the drain of 0x40 in the same cycle.
- Read-after-write hazard: store 0x20 (0x12345678) in cycle 0, `ram_busy`=1 in cycle 1, load 0x22 from cycle 1.
  - Required: cycle 1 `cpu_stall`=1.
  - Required: cycle 2 drain of 0x20 with `cpu_stall`=1.
  - Required: cycle 3 read issued; cycle 4 `cpu_rdata`=0x12345678.
- Full: `ram_busy`=1, stores to 0x0, 0x4, 0x8, 0xC, then a fifth store.
  - Required: `buf_count`=4 and the fifth store stalls.
  - Then drop `ram_busy`: required drains in address order 0x0, 0x4, 0x8, 0xC, one per cycle. The fifth store is accepted in the first drain cycle+1, and the pointers wrap correctly.
- Byte lanes: store be=4'b0010 to 0x30.
  - Required: `ram_wea`=4'b0010 and `ram_addr`=0x30 on the drain cycle.
